// File: rtl/alu_exec_unit.sv
// Execute stage behind the 16x16 register file. Single-cycle logic/arith ops,
// a 16-step shift-add multiply, and a one-cycle write strobe to the register file.
module alu_exec_unit #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [ADDR_W-1:0] dest,
    output logic              busy,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [WIDTH-1:0]  wb_data,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              err
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SHL   = 4'd5;
    localparam logic [3:0] OP_SHR   = 4'd6;
    localparam logic [3:0] OP_MUL   = 4'd7;
    localparam logic [3:0] OP_PASSB = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [ADDR_W-1:0]   dest_q, dest_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic                wb_we_q, wb_we_d;
    logic [ADDR_W-1:0]   wb_dest_q, wb_dest_d;
    logic [WIDTH-1:0]    wb_data_q, wb_data_d;
    logic                flag_z_q, flag_z_d;
    logic                flag_n_q, flag_n_d;
    logic                flag_c_q, flag_c_d;
    logic                err_q, err_d;

    logic [WIDTH-1:0]    alu_res_s;
    logic                alu_c_s;
    logic [WIDTH:0]      sum_s;
    logic [WIDTH:0]      diff_s;
    logic [2*WIDTH-1:0]  mul_part_s;
    logic [2*WIDTH-1:0]  mul_acc_s;

    // Single-cycle ALU result and carry from the latched operands
    always_comb begin
        sum_s     = {1'b0, a_q} + {1'b0, b_q};
        diff_s    = {1'b0, a_q} - {1'b0, b_q};
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
            end
            OP_SUB: begin
                // the extra top bit of the widened difference is the borrow
                alu_res_s = diff_s[WIDTH-1:0];
                alu_c_s   = diff_s[WIDTH];
            end
            OP_AND:   alu_res_s = a_q & b_q;
            OP_OR:    alu_res_s = a_q | b_q;
            OP_XOR:   alu_res_s = a_q ^ b_q;
            OP_SHL:   alu_res_s = a_q << b_q[3:0];
            OP_SHR:   alu_res_s = a_q >> b_q[3:0];
            OP_PASSB: alu_res_s = b_q;
            default: begin
                alu_res_s = {WIDTH{1'b0}};
                alu_c_s   = 1'b0;
            end
        endcase
    end

    // One shift-add multiply step: add a<<cnt when bit cnt of b is set
    always_comb begin
        if (b_q[cnt_q]) begin
            mul_part_s = {{WIDTH{1'b0}}, a_q} << cnt_q;
        end else begin
            mul_part_s = {(2*WIDTH){1'b0}};
        end
        mul_acc_s = acc_q + mul_part_s;
    end

    // Next-state, operand latch and write-back decode
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        dest_d    = dest_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        wb_we_d   = 1'b0;
        err_d     = 1'b0;
        wb_dest_d = wb_dest_q;
        wb_data_d = wb_data_q;
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
        flag_c_d  = flag_c_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d   = op;
                    a_d    = a;
                    b_d    = b;
                    dest_d = dest;
                    if (op == OP_MUL) begin
                        state_d = ST_MUL;
                        cnt_d   = {CNT_W{1'b0}};
                        acc_d   = {(2*WIDTH){1'b0}};
                    end else if (op > OP_PASSB) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d   = ST_IDLE;
                wb_we_d   = 1'b1;
                wb_dest_d = dest_q;
                wb_data_d = alu_res_s;
                flag_z_d  = (alu_res_s == {WIDTH{1'b0}});
                flag_n_d  = alu_res_s[WIDTH-1];
                flag_c_d  = alu_c_s;
            end
            ST_MUL: begin
                acc_d = mul_acc_s;
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    wb_we_d   = 1'b1;
                    wb_dest_d = dest_q;
                    wb_data_d = mul_acc_s[WIDTH-1:0];
                    flag_z_d  = (mul_acc_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    flag_n_d  = mul_acc_s[WIDTH-1];
                    flag_c_d  = (mul_acc_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
                end else begin
                    state_d = ST_MUL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; clr discards any in-flight operation
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            op_q      <= 4'd0;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            dest_q    <= {ADDR_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            wb_we_q   <= 1'b0;
            wb_dest_q <= {ADDR_W{1'b0}};
            wb_data_q <= {WIDTH{1'b0}};
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            dest_q    <= dest_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            wb_we_q   <= wb_we_d;
            wb_dest_q <= wb_dest_d;
            wb_data_q <= wb_data_d;
            flag_z_q  <= flag_z_d;
            flag_n_q  <= flag_n_d;
            flag_c_q  <= flag_c_d;
            err_q     <= err_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign wb_we   = wb_we_q;
    assign wb_dest = wb_dest_q;
    assign wb_data = wb_data_q;
    assign flag_z  = flag_z_q;
    assign flag_n  = flag_n_q;
    assign flag_c  = flag_c_q;
    assign err     = err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expected results.
module tb_alu_exec_unit;

    logic        clk;
    logic        clr;
    logic        start;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  dest;
    logic        busy;
    logic        wb_we;
    logic [3:0]  wb_dest;
    logic [15:0] wb_data;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
    logic        err;

    int n_checks;
    int n_fail;

    alu_exec_unit #(.WIDTH(16), .ADDR_W(4)) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .dest    (dest),
        .busy    (busy),
        .wb_we   (wb_we),
        .wb_dest (wb_dest),
        .wb_data (wb_data),
        .flag_z  (flag_z),
        .flag_n  (flag_n),
        .flag_c  (flag_c),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags packed as {n, z, c}
    task automatic run_simple(input string tag, input logic [3:0] op_i, input logic [15:0] a_i,
                              input logic [15:0] b_i, input logic [3:0] dest_i,
                              input logic [15:0] exp_data, input logic [2:0] exp_nzc);
        start = 1'b1; op = op_i; a = a_i; b = b_i; dest = dest_i;
        tick();
        start = 1'b0;
        check_eq({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
        check_eq({tag, "_we_e0"}, {31'd0, wb_we}, 32'd0);
        tick();
        check_eq({tag, "_we_e1"}, {31'd0, wb_we}, 32'd1);
        check_eq({tag, "_data"}, {16'd0, wb_data}, {16'd0, exp_data});
        check_eq({tag, "_dest"}, {28'd0, wb_dest}, {28'd0, dest_i});
        check_eq({tag, "_nzc"}, {29'd0, flag_n, flag_z, flag_c}, {29'd0, exp_nzc});
        check_eq({tag, "_busy_e1"}, {31'd0, busy}, 32'd0);
        tick();
        check_eq({tag, "_we_e2"}, {31'd0, wb_we}, 32'd0);
        check_eq({tag, "_nzc_held"}, {29'd0, flag_n, flag_z, flag_c}, {29'd0, exp_nzc});
    endtask

    task automatic run_mul(input string tag, input logic [15:0] a_i, input logic [15:0] b_i,
                           input logic [3:0] dest_i, input logic [15:0] exp_data,
                           input logic [2:0] exp_nzc, input bit noisy);
        int we_cnt;
        we_cnt = 0;
        start = 1'b1; op = 4'd7; a = a_i; b = b_i; dest = dest_i;
        tick();
        start = 1'b0;
        for (int i = 1; i < 16; i++) begin
            if (noisy && i < 15) begin
                start = i[0]; op = 4'd0; a = 16'h1111; b = 16'h2222; dest = 4'd9;
            end else begin
                start = 1'b0;
            end
            tick();
            check_eq({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
            we_cnt += int'(wb_we);
        end
        start = 1'b0;
        check_eq({tag, "_no_early_we"}, we_cnt, 32'd0);
        tick();
        we_cnt += int'(wb_we);
        check_eq({tag, "_we_e16"}, {31'd0, wb_we}, 32'd1);
        check_eq({tag, "_data"}, {16'd0, wb_data}, {16'd0, exp_data});
        check_eq({tag, "_dest"}, {28'd0, wb_dest}, {28'd0, dest_i});
        check_eq({tag, "_nzc"}, {29'd0, flag_n, flag_z, flag_c}, {29'd0, exp_nzc});
        check_eq({tag, "_busy_e16"}, {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            we_cnt += int'(wb_we);
        end
        check_eq({tag, "_we_count"}, we_cnt, 32'd1);
    endtask

    initial begin
        int we_cnt;
        int prev_we;
        int adjacent;
        n_checks = 0;
        n_fail   = 0;
        clr = 1'b1; start = 1'b0; op = 4'd0; a = 16'd0; b = 16'd0; dest = 4'd0;

        // reset state
        tick();
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_we", {31'd0, wb_we}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_data", {16'd0, wb_data}, 32'd0);
        check_eq("rst_dest", {28'd0, wb_dest}, 32'd0);
        check_eq("rst_flags", {29'd0, flag_n, flag_z, flag_c}, 32'd0);
        tick();
        clr = 1'b0;
        tick();

        // single-cycle ops
        run_simple("add_ovf",  4'd0, 16'h7FFF, 16'h0001, 4'd3,  16'h8000, 3'b100);
        run_simple("sub_neg",  4'd1, 16'h0003, 16'h0005, 4'd4,  16'hFFFE, 3'b101);
        run_simple("sub_zero", 4'd1, 16'h0005, 16'h0005, 4'd5,  16'h0000, 3'b010);
        run_simple("add_carry",4'd0, 16'hFFFF, 16'h0001, 4'd6,  16'h0000, 3'b011);
        run_simple("and",      4'd2, 16'hF0F0, 16'h0FF0, 4'd7,  16'h00F0, 3'b000);
        run_simple("or",       4'd3, 16'hF000, 16'h000F, 4'd8,  16'hF00F, 3'b100);
        run_simple("xor",      4'd4, 16'hFFFF, 16'hFFFF, 4'd9,  16'h0000, 3'b010);
        run_simple("shr15",    4'd6, 16'h8000, 16'h000F, 4'd10, 16'h0001, 3'b000);
        run_simple("shl0",     4'd5, 16'h1234, 16'h0010, 4'd11, 16'h1234, 3'b000);
        run_simple("passb",    4'd8, 16'h1111, 16'hABCD, 4'd12, 16'hABCD, 3'b100);

        // multiply: 300*300 = 0x15F90, 255*257 = 0xFFFF
        run_mul("mul300", 16'd300, 16'd300, 4'd13, 16'h5F90, 3'b001, 1'b1);
        run_mul("mul255", 16'h00FF, 16'h0101, 4'd14, 16'hFFFF, 3'b100, 1'b0);

        // clr in the middle of a multiply
        start = 1'b1; op = 4'd7; a = 16'd300; b = 16'd300; dest = 4'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        clr = 1'b1;
        #1;
        check_eq("clr_busy", {31'd0, busy}, 32'd0);
        check_eq("clr_we", {31'd0, wb_we}, 32'd0);
        check_eq("clr_data", {16'd0, wb_data}, 32'd0);
        check_eq("clr_dest", {28'd0, wb_dest}, 32'd0);
        check_eq("clr_flags", {29'd0, flag_n, flag_z, flag_c}, 32'd0);
        tick();
        clr = 1'b0;
        we_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            we_cnt += int'(wb_we);
        end
        check_eq("clr_no_we", we_cnt, 32'd0);
        run_simple("add_after_clr", 4'd0, 16'h0001, 16'h0001, 4'd1, 16'h0002, 3'b000);

        // illegal opcode leaves flags from the preceding SUB alone
        run_simple("sub_pre_ill", 4'd1, 16'h0003, 16'h0005, 4'd4, 16'hFFFE, 3'b101);
        start = 1'b1; op = 4'hA; a = 16'h0001; b = 16'h0001; dest = 4'd15;
        tick();
        start = 1'b0;
        check_eq("ill_err", {31'd0, err}, 32'd1);
        check_eq("ill_we", {31'd0, wb_we}, 32'd0);
        check_eq("ill_busy", {31'd0, busy}, 32'd0);
        check_eq("ill_flags", {29'd0, flag_n, flag_z, flag_c}, 32'h5);
        tick();
        check_eq("ill_err_clear", {31'd0, err}, 32'd0);
        check_eq("ill_we_after", {31'd0, wb_we}, 32'd0);

        // start held high: back-to-back SHL every 2 cycles
        start = 1'b1; op = 4'd5; a = 16'h0001; b = 16'h0004; dest = 4'd3;
        we_cnt = 0; prev_we = 0; adjacent = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (wb_we) begin
                we_cnt++;
                check_eq("shl_rep_data", {16'd0, wb_data}, 32'h0010);
            end
            if (wb_we && prev_we != 0) adjacent++;
            prev_we = int'(wb_we);
        end
        start = 1'b0;
        check_eq("shl_rep_count", we_cnt, 32'd6);
        check_eq("shl_rep_adjacent", adjacent, 32'd0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
